// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press and release debouncing.
// Produces one key_valid pulse with the decoded key_code per physical press.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_busy
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_RELEASE = 2'd2,
        RELEASE_DB   = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      row_meta_reg, row_s_reg;
    logic [DW-1:0]   dwell_reg, dwell_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      col_reg, col_next;
    logic [3:0]      pat_reg, pat_next;
    logic            valid_reg, valid_next;
    logic [3:0]      code_reg, code_next;
    logic [1:0]      row_idx;
    logic            one_low;

    // Row order r0..r3, column order c0..c3; '*' = E, '#' = F.
    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: map_key = 4'h1;  4'h1: map_key = 4'h2;  4'h2: map_key = 4'h3;  4'h3: map_key = 4'hA;
            4'h4: map_key = 4'h4;  4'h5: map_key = 4'h5;  4'h6: map_key = 4'h6;  4'h7: map_key = 4'hB;
            4'h8: map_key = 4'h7;  4'h9: map_key = 4'h8;  4'hA: map_key = 4'h9;  4'hB: map_key = 4'hC;
            4'hC: map_key = 4'hE;  4'hD: map_key = 4'h0;  4'hE: map_key = 4'hF;  default: map_key = 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_reg <= 4'hF;
            row_s_reg    <= 4'hF;
            state_reg    <= SCAN;
            dwell_reg    <= '0;
            cnt_reg      <= '0;
            col_reg      <= 2'd0;
            pat_reg      <= 4'hF;
            valid_reg    <= 1'b0;
            code_reg     <= 4'h0;
        end else begin
            row_meta_reg <= row_n;
            row_s_reg    <= row_meta_reg;
            state_reg    <= state_next;
            dwell_reg    <= dwell_next;
            cnt_reg      <= cnt_next;
            col_reg      <= col_next;
            pat_reg      <= pat_next;
            valid_reg    <= valid_next;
            code_reg     <= code_next;
        end
    end

    assign one_low = $onehot(~row_s_reg);

    always_comb begin
        row_idx = 2'd0;
        case (pat_reg)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        dwell_next = dwell_reg;
        cnt_next   = cnt_reg;
        col_next   = col_reg;
        pat_next   = pat_reg;
        valid_next = 1'b0;
        code_next  = code_reg;
        case (state_reg)
            SCAN: begin
                if (dwell_reg == DWELL_LAST) begin
                    dwell_next = '0;
                    if (one_low) begin
                        pat_next   = row_s_reg;
                        cnt_next   = '0;
                        state_next = DEBOUNCE;
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end else begin
                    dwell_next = dwell_reg + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s_reg == pat_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        valid_next = 1'b1;
                        code_next  = map_key(row_idx, col_reg);
                        state_next = WAIT_RELEASE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    dwell_next = '0;
                    state_next = SCAN;
                end
            end
            WAIT_RELEASE: begin
                if (row_s_reg == 4'hF) begin
                    cnt_next   = '0;
                    state_next = RELEASE_DB;
                end
            end
            default: begin
                if (row_s_reg == 4'hF) begin
                    if (cnt_reg == CNT_LAST) begin
                        col_next   = col_reg + 2'd1;
                        dwell_next = '0;
                        state_next = SCAN;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else begin
                    state_next = WAIT_RELEASE;
                end
            end
        endcase
    end

    // Column drive is a one-hot-low decode of the current column index.
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign col_n[gi] = (col_reg != 2'(gi));
    end

    assign key_valid = valid_reg;
    assign key_code  = code_reg;
    assign key_busy  = (state_reg != SCAN);
endmodule
